uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- UART transmit engine; the transmit-side counterpart of the UART receive path.
- Accepts a parallel word through a valid/busy handshake and serializes it onto TX_OUT as start, data (LSB first), optional parity and stop bits.
- Each bit is held for `prescale` clk cycles, the same per-bit oversampling ratio the receiver uses.
- Bit timing is generated internally by a per-bit edge counter.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input and of the internal edge counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- P_DATA  input  DATA_WIDTH  parallel word to send.
- DATA_VALID  input  1  request; accepted only in IDLE.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- prescale  input  PRESCALE_WIDTH  clk cycles per bit.
- TX_OUT  output  1  serial line; idles at 1.
- busy  output  1  high from the cycle after accept until the frame ends.
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (rst=1 at a clk edge):
  - TX_OUT=1, busy=0, frame_done=0, FSM=IDLE, edge and bit counters=0.
  - Reset mid-frame aborts the frame at once; TX_OUT returns to 1 on the next edge.
- All outputs are registered.
- Accept:
  - In IDLE with DATA_VALID=1 at edge n: latch P_DATA, PAR_EN, PAR_TYP and prescale.
  - Parity is computed from the latched data: even = XOR of data bits; odd = its inverse.
  - From edge n+1: TX_OUT=0 (start bit) and busy=1.
  - DATA_VALID while busy=1 is ignored, not queued.
  - Input changes after accept have no effect on the frame in progress.
- Prescale rule: a latched prescale of 0 is treated as 1.
- FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
  - Each non-IDLE state lasts P clk cycles (P = latched prescale).
  - The edge counter runs 0..P-1 and wraps to 0 at the end of each bit.
  - The bit counter advances on each wrap.
  - DATA lasts DATA_WIDTH bits; TX_OUT = data[bit_cnt], LSB first.
  - PARITY: TX_OUT = parity bit. STOP: TX_OUT = 1.
- Frame length: (DATA_WIDTH + 2 + PAR_EN) × P cycles from edge n+1.
- End of frame:
  - frame_done=1 in the final cycle of STOP.
  - The next edge enters IDLE with busy=0.
  - A new DATA_VALID is accepted in IDLE on that cycle or later, giving at least one idle-high cycle between frames.
- Counter wrap at max prescale (2^PRESCALE_WIDTH−1) must not overflow; compare with ==, never with an increment into the next bit of width.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2×P cycles; frame_done pulses in the last cycle of the second stop bit; frame length grows by P.
- Undefined: one stop bit, as in Behaviour.

Decomposition:
- Shared package/header uart_pkg holds:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP).
  - PAR_EVEN=0 and PAR_ODD=1 constants.
  - Default DATA_WIDTH and PRESCALE_WIDTH.
- One natural sub-module: uart_tx_bit_timer.
  - Contains the edge counter and the bit counter.
  - Inputs: enable, prescale. Outputs: bit_tick, bit_cnt.
  - The top level holds the FSM, the latches, parity and the output mux.

Test Plan:
- P_DATA=8'hA5, PAR_EN=0, prescale=8, one-cycle DATA_VALID:
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
  - busy high 80 cycles; frame_done pulses at cycle 80.
- P_DATA=8'h07, PAR_EN=1, PAR_TYP=0, prescale=4: parity bit=1; frame is 44 cycles. Repeat with PAR_TYP=1: parity bit=0.
- DATA_VALID held high continuously with P_DATA=8'h3C then 8'hC3:
  - Second word is accepted only in IDLE.
  - At least one TX_OUT=1 idle cycle separates the frames.
  - Changing P_DATA mid-frame does not corrupt the first frame.
- prescale=0 with P_DATA=8'hFF: behaves as prescale=1; frame is 10 cycles. prescale=63: frame is 630 cycles with no counter wrap error.
- rst pulsed for one cycle in the middle of DATA: next cycle TX_OUT=1, busy=0, FSM=IDLE. A following DATA_VALID sends a clean full frame.
- With UART_TX_TWO_STOP_EN, P_DATA=8'h55, prescale=2: stop level held 4 cycles; frame is 22 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity
// selection constants and default widths.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: an edge counter running 0..P-1 per
// bit and a frame bit counter that advances on every wrap.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_tick,
  output logic                      bit_tick_next,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt
);

  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE = PRESCALE_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE  = BIT_CNT_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] edge_next;
  logic [PRESCALE_WIDTH-1:0] last_edge;

  // prescale is never 0 here, so P-1 cannot underflow and the counter
  // never needs to reach 2^PRESCALE_WIDTH.
  assign last_edge = prescale - EDGE_ONE;
  assign bit_tick  = enable && (edge_cnt == last_edge);

  always_comb begin
    // NOTE: combinational blocks assign a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    edge_next = edge_cnt + EDGE_ONE;
    if (!enable || bit_tick) begin
      edge_next = '0;
    end
  end

  // Lookahead: the coming cycle is the last cycle of its bit.
  assign bit_tick_next = (edge_next == last_edge);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= edge_next;
      if (bit_tick) begin
        bit_cnt <= bit_cnt + BIT_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start, LSB-first data, optional parity and stop bits.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic                      frame_done
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  // Frame bit index: 0 = start, 1..DATA_WIDTH = data, then parity, then stop.
  localparam int BIT_CNT_WIDTH  = $clog2(DATA_WIDTH + 4);
  localparam int DATA_IDX_WIDTH = $clog2(DATA_WIDTH);

  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE         = BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  LAST_DATA_IDX   = BIT_CNT_WIDTH'(DATA_WIDTH);
  localparam logic [BIT_CNT_WIDTH-1:0]  LAST_STOP_NOPAR = BIT_CNT_WIDTH'(DATA_WIDTH + STOP_BITS);
  localparam logic [BIT_CNT_WIDTH-1:0]  LAST_STOP_PAR   = BIT_CNT_WIDTH'(DATA_WIDTH + 1 + STOP_BITS);
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE    = PRESCALE_WIDTH'(1);

  uart_state_e state;
  uart_state_e state_next;

  logic [DATA_WIDTH-1:0]     data_lat;
  logic                      par_en_lat;
  logic                      par_typ_lat;
  logic [PRESCALE_WIDTH-1:0] p_lat;

  logic                      accept;
  logic                      bit_tick;
  logic                      bit_tick_next;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_nxt;
  logic [BIT_CNT_WIDTH-1:0]  last_stop_idx;
  logic [DATA_IDX_WIDTH-1:0] data_idx;
  logic                      par_bit;

  logic tx_next;
  logic busy_next;
  logic done_next;

  assign accept = (state == ST_IDLE) && DATA_VALID;

  // Frame parameters are frozen at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath latches are reset too so the first frame after
      // reset never sees X, though accept always overwrites them.
      data_lat    <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= PAR_EVEN;
      p_lat       <= PRESCALE_ONE;
    end else if (accept) begin
      data_lat    <= P_DATA;
      par_en_lat  <= PAR_EN;
      par_typ_lat <= PAR_TYP;
      p_lat       <= (prescale == '0) ? PRESCALE_ONE : prescale;
    end
  end

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .enable       (state != ST_IDLE),
    .prescale     (p_lat),
    .bit_tick     (bit_tick),
    .bit_tick_next(bit_tick_next),
    .bit_cnt      (bit_cnt)
  );

  assign last_stop_idx = par_en_lat ? LAST_STOP_PAR : LAST_STOP_NOPAR;
  assign bit_nxt       = bit_tick ? (bit_cnt + BIT_ONE) : bit_cnt;
  assign data_idx      = DATA_IDX_WIDTH'(bit_nxt - BIT_ONE);

  always_comb begin
    par_bit = ^data_lat;
    unique case (par_typ_lat)
      PAR_EVEN: par_bit = ^data_lat;
      PAR_ODD:  par_bit = ~(^data_lat);
      default:  par_bit = ^data_lat;
    endcase
  end

  // State register; the outputs are registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      TX_OUT     <= tx_next;
      busy       <= busy_next;
      frame_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (DATA_VALID) state_next = ST_START;
      ST_START:  if (bit_tick) state_next = ST_DATA;
      ST_DATA: begin
        if (bit_tick && (bit_cnt == LAST_DATA_IDX)) begin
          state_next = par_en_lat ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_tick) state_next = ST_STOP;
      ST_STOP:   if (bit_tick && (bit_cnt == last_stop_idx)) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state and the
  // next bit index so the registered outputs line up with the state.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != ST_IDLE);
    done_next = 1'b0;
    unique case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = data_lat[data_idx];
      ST_PARITY: tx_next = par_bit;
      ST_STOP:   done_next = bit_tick_next && (bit_nxt == last_stop_idx);
      default:   tx_next = 1'b1;
    endcase
  end

endmodule
